// File: rtl/instr_mem_responder.sv
// Memory-side responder for the processor fetch/data port: detects a new
// access, waits LATENCY clocks, then reads or writes the word array.
module instr_mem_responder #(
  parameter int unsigned  DEPTH   = 256,
  parameter int unsigned  LATENCY = 2,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr,
  input  logic          rw,
  input  logic [31:0]   out,
  input  logic          sys_dne,
  output logic [31:0]   instruction,
  output logic          ready,
  output logic          err,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_addr_q;
  logic [31:0] a_data_q;
  logic        a_rw_q;
  logic        seen_valid_q;
  logic [31:0] instruction_q;
  logic        ready_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  logic          new_access_c;
  logic          complete_c;
  logic          in_range_c;
  logic [AW-1:0] a_idx_c;

  assign new_access_c = !seen_valid_q || (addr != a_addr_q) || (rw != a_rw_q);
  assign complete_c   = (state_q == WAIT) && (cnt_q == 4'd1);
  assign in_range_c   = (a_addr_q < 32'(DEPTH));
  assign a_idx_c      = a_addr_q[AW-1:0];

  // Access sequencing and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      a_addr_q      <= 32'd0;
      a_data_q      <= 32'd0;
      a_rw_q        <= 1'b0;
      seen_valid_q  <= 1'b0;
      instruction_q <= 32'd0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sys_dne) begin
            state_q <= HALT;
          end else if (new_access_c) begin
            a_addr_q     <= addr;
            a_rw_q       <= rw;
            a_data_q     <= out;
            seen_valid_q <= 1'b1;
            cnt_q        <= 4'(LATENCY);
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (complete_c) begin
            // Writes leave instruction untouched; out-of-range reads return zero.
            if (!a_rw_q) begin
              instruction_q <= in_range_c ? mem_q[a_idx_c] : 32'd0;
            end
            ready_q <= 1'b1;
            err_q   <= !in_range_c;
            cnt_q   <= 4'd0;
            state_q <= sys_dne ? HALT : IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Word array; the backdoor load is ordered last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (complete_c && a_rw_q && in_range_c) begin
      mem_q[a_idx_c] <= a_data_q;
    end
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign instruction = instruction_q;
  assign ready       = ready_q;
  assign err         = err_q;

endmodule
